// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: one-cycle ingress holdoff, first-word-fall-through egress, sticky overflow.
// Optional macro UART_RX_FIFO_BACKPRESSURE_EN stalls the receiver when full instead of dropping bytes.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock_12MHz,
   input  logic                  reset_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  overflow_clear
);

   localparam int                    DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = (DEPTH_LOG2+1)'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
   localparam logic [0:0]            ST_READY   = 1'b0;
   localparam logic [0:0]            ST_HOLDOFF = 1'b1;

   logic [7:0]            mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic [0:0]            state_r;
   logic                  overflow_r;
   logic                  full_s;
   logic                  empty_s;
   logic                  in_ready_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  store_s;
   logic                  drop_s;

   // Handshake decode; a pop on a full buffer frees the slot for a same-cycle push.
   always_comb begin
      full_s  = (count_r == FULL_COUNT);
      empty_s = (count_r == CNT_ZERO);
`ifdef UART_RX_FIFO_BACKPRESSURE_EN
      in_ready_s = (state_r == ST_READY) && !full_s;
`else
      in_ready_s = (state_r == ST_READY);
`endif
      push_s  = in_valid && in_ready_s;
      pop_s   = !empty_s && out_ready;
      store_s = push_s && (!full_s || pop_s);
      drop_s  = push_s && full_s && !pop_s;
   end

   // Ingress FSM: after each accepted byte, ignore the receiver's stale valid for one cycle.
   always_ff @(posedge clock_12MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_HOLDOFF;
      end else begin
         case (state_r)
            ST_READY:   state_r <= push_s ? ST_HOLDOFF : ST_READY;
            ST_HOLDOFF: state_r <= ST_READY;
            default:    state_r <= ST_HOLDOFF;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty because the read is masked.
   always_ff @(posedge clock_12MHz) begin
      if (store_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointers, fill level and sticky overflow; a set beats a same-cycle clear.
   always_ff @(posedge clock_12MHz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (store_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (store_s && !pop_s) begin
            count_r <= count_r + CNT_ONE;
         end else if (pop_s && !store_s) begin
            count_r <= count_r - CNT_ONE;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (overflow_clear) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = !empty_s;
   assign out_data  = empty_s ? 8'h00 : mem_r[rd_ptr_r];
   assign count     = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based model predicts every output; a negedge monitor checks popped bytes.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_BACKPRESSURE_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic       clock_12MHz = 1'b0;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] count;
   logic       overflow;
   logic       overflow_clear;

   int         compared   = 0;
   int         mismatched = 0;

   // Reference model: queue of bytes held, plus holdoff and overflow flags.
   logic [7:0] exp_q[$];
   int         m_cnt;
   bit         m_hold;
   bit         m_ovf;

   uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clock_12MHz    (clock_12MHz),
      .reset_n        (reset_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count          (count),
      .overflow       (overflow),
      .overflow_clear (overflow_clear)
   );

   always #5 clock_12MHz = ~clock_12MHz;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return !m_hold && (!BP || m_cnt < DEPTH);
   endfunction

   task automatic check_status();
      check("in_ready", int'(in_ready), int'(m_ready()));
      check("out_valid", int'(out_valid), int'(m_cnt > 0));
      check("count", int'(count), m_cnt);
      check("overflow", int'(overflow), int'(m_ovf));
      check("out_data", int'(out_data), (m_cnt > 0 && exp_q.size() > 0) ? int'(exp_q[0]) : 0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt  = 0;
      m_hold = 1'b1;
      m_ovf  = 1'b0;
   endtask

   // One clock cycle: drive inputs, let the edge happen, advance the model, compare status.
   task automatic step(input bit iv, input logic [7:0] d, input bit ordy, input bit oclr);
      bit push, pop, stored;
      in_valid       = iv;
      in_data        = d;
      out_ready      = ordy;
      overflow_clear = oclr;
      push = iv && m_ready();
      pop  = ordy && (m_cnt > 0);
      @(posedge clock_12MHz);
      #1;
      stored = push && (m_cnt < DEPTH || pop);
      if (stored) exp_q.push_back(d);
      if (push && !stored) m_ovf = 1'b1;
      else if (oclr) m_ovf = 1'b0;
      m_cnt  = m_cnt + int'(stored) - int'(pop);
      m_hold = push;
      check_status();
   endtask

   // Monitor: every pop handshake must present the oldest expected byte.
   always @(negedge clock_12MHz) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", int'(out_data), -1);
         end else begin
            check("pop_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mx;
      reset_n = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; overflow_clear = 1'b0;
      model_reset();
      #12;
      check_status();
      @(posedge clock_12MHz); #1;
      reset_n = 1'b1;

      // Reset then a single byte held valid for two cycles.
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      check("single_count", int'(count), 1);
      check("single_data", int'(out_data), 8'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Order and wrap-around with continuous popping and a stale valid each byte.
      mx = 0;
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b0);
         if (int'(count) > mx) mx = int'(count);
         step(1'b1, 8'(i), 1'b1, 1'b0);
         if (int'(count) > mx) mx = int'(count);
      end
      check("wrap_max_count_le2", int'(mx <= 2), 1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Seventeen pushes without popping, drain, then clear overflow.
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      check("fill_count", int'(count), 16);
      for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_cleared", int'(overflow), 0);

      // Full buffer with a push in the same cycle as a pop.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      step(1'b1, 8'h77, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Full buffer with a pending byte, then one pop.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      step(1'b1, 8'h99, 1'b1, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

      // Randomized traffic: a congested phase then a draining phase.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) != 0, 8'($urandom),
              (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

      // Asynchronous reset asserted off-edge with five bytes buffered.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      check("pre_reset_count", int'(count), 5);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_count", int'(count), 0);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_in_ready", int'(in_ready), 0);
      check("arst_out_data", int'(out_data), 0);
      model_reset();
      @(posedge clock_12MHz); #1;
      reset_n = 1'b1;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
